// File: rtl/fpu_i2f_arbiter_if.sv
// rtl/fpu_i2f_arbiter_if.sv - requester and converter handshake bundle for fpu_i2f_arbiter
interface fpu_i2f_arbiter_if #(
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0]    req_stb;
   logic [32*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]    req_ack;
   logic [N_REQ-1:0]    resp_stb;
   logic [31:0]         resp_data;
   logic [N_REQ-1:0]    resp_ack;
   logic [31:0]         cvt_a;
   logic                cvt_a_stb;
   logic                cvt_a_ack;
   logic [31:0]         cvt_z;
   logic                cvt_z_stb;
   logic                cvt_z_ack;

   modport master (
      input  req_stb, req_data, resp_ack, cvt_a_ack, cvt_z, cvt_z_stb,
      output req_ack, resp_stb, resp_data, cvt_a, cvt_a_stb, cvt_z_ack
   );

   modport slave (
      output req_stb, req_data, resp_ack, cvt_a_ack, cvt_z, cvt_z_stb,
      input  req_ack, resp_stb, resp_data, cvt_a, cvt_a_stb, cvt_z_ack
   );
endinterface

// File: rtl/fpu_i2f_arbiter.sv
// rtl/fpu_i2f_arbiter.sv - round-robin sharing of one int_to_float converter between N_REQ requesters
module fpu_i2f_arbiter #(
   parameter int N_REQ   = 2,
   parameter int ID_W    = 1,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   fpu_i2f_arbiter_if.master bus,
   output logic              busy,
   output logic [ID_W-1:0]   grant_id,
   output logic              timeout_err
);
   localparam int                WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
   localparam logic [N_REQ-1:0]  ONE     = N_REQ'(1);
   localparam logic [ID_W-1:0]   LAST_ID = ID_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RETURN
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [31:0]       operand_q, operand_d;
   logic [31:0]       result_q, result_d;
   logic [N_REQ-1:0]  req_ack_q, req_ack_d;
   logic [N_REQ-1:0]  resp_stb_q, resp_stb_d;
   logic              a_stb_q, a_stb_d;
   logic              z_ack_q, z_ack_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              terr_q, terr_d;
   logic              busy_q, busy_d;

   logic              found;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   cand;

   // First requester at or after rr_ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
         if (!found && bus.req_stb[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      operand_d  = operand_q;
      result_d   = result_q;
      req_ack_d  = '0;
      resp_stb_d = resp_stb_q;
      a_stb_d    = a_stb_q;
      z_ack_d    = z_ack_q;
      wdog_d     = wdog_q;
      terr_d     = terr_q;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d   = pick;
               operand_d = bus.req_data[{pick, 5'd0} +: 32];
               req_ack_d = ONE << pick;
               a_stb_d   = 1'b1;
               wdog_d    = '0;
               state_d   = S_ISSUE;
            end
         end

         S_ISSUE: begin
            wdog_d = wdog_q + WD_W'(1);
            if (wdog_q == WD_LAST) begin
               a_stb_d    = 1'b0;
               terr_d     = 1'b1;
               result_d   = QNAN;
               resp_stb_d = ONE << grant_q;
               state_d    = S_RETURN;
            end else if (bus.cvt_a_ack) begin
               a_stb_d = 1'b0;
               z_ack_d = 1'b1;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            wdog_d = wdog_q + WD_W'(1);
            // A result arriving on the expiry cycle is still delivered.
            if (bus.cvt_z_stb && z_ack_q) begin
               z_ack_d    = 1'b0;
               result_d   = bus.cvt_z;
               resp_stb_d = ONE << grant_q;
               state_d    = S_RETURN;
            end else if (wdog_q == WD_LAST) begin
               z_ack_d    = 1'b0;
               terr_d     = 1'b1;
               result_d   = QNAN;
               resp_stb_d = ONE << grant_q;
               state_d    = S_RETURN;
            end
         end

         S_RETURN: begin
            if (bus.resp_ack[grant_q]) begin
               resp_stb_d = '0;
               rr_ptr_d   = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);
               state_d    = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         operand_q  <= '0;
         result_q   <= '0;
         req_ack_q  <= '0;
         resp_stb_q <= '0;
         a_stb_q    <= 1'b0;
         z_ack_q    <= 1'b0;
         wdog_q     <= '0;
         terr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         operand_q  <= operand_d;
         result_q   <= result_d;
         req_ack_q  <= req_ack_d;
         resp_stb_q <= resp_stb_d;
         a_stb_q    <= a_stb_d;
         z_ack_q    <= z_ack_d;
         wdog_q     <= wdog_d;
         terr_q     <= terr_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.req_ack   = req_ack_q;
   assign bus.resp_stb  = resp_stb_q;
   assign bus.resp_data = result_q;
   assign bus.cvt_a     = operand_q;
   assign bus.cvt_a_stb = a_stb_q;
   assign bus.cvt_z_ack = z_ack_q;
   assign busy          = busy_q;
   assign grant_id      = grant_q;
   assign timeout_err   = terr_q;
endmodule

// File: tb/tb_fpu_i2f_arbiter.sv
// tb/tb_fpu_i2f_arbiter.sv - randomized self-checking bench for fpu_i2f_arbiter
module tb_fpu_i2f_arbiter;
   localparam int N_REQ   = 2;
   localparam int ID_W    = 1;
   localparam int TIMEOUT = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            busy;
   logic [ID_W-1:0] grant_id;
   logic            timeout_err;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;

   logic        cvt_ready = 1'b1;
   logic        cvt_hang  = 1'b0;
   logic        pending;
   int          pend_delay;
   logic [31:0] pend_op;
   logic        nxt_a_hs, nxt_z_hs;
   logic [31:0] nxt_a;

   fpu_i2f_arbiter_if #(.N_REQ(N_REQ)) bus ();

   fpu_i2f_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Round-to-nearest-even signed integer to single precision.
   function automatic logic [31:0] ref_i2f(input logic [31:0] v);
      logic [31:0] a;
      logic [63:0] mag, keep, rem, half;
      int msb, sh;
      logic [7:0] e;
      if (v == 32'd0) return 32'd0;
      a = v[31] ? -v : v;
      mag = {32'd0, a};
      msb = 0;
      for (int i = 0; i < 64; i++) if (mag[i]) msb = i;
      if (msb <= 23) begin
         keep = mag << (23 - msb);
      end else begin
         sh   = msb - 23;
         keep = mag >> sh;
         rem  = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
         if (keep[24]) begin
            keep = keep >> 1;
            msb++;
         end
      end
      e = 8'(msb + 127);
      return {v[31], e, keep[22:0]};
   endfunction

   function automatic logic [N_REQ-1:0] oh(input int i);
      logic [N_REQ-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   function automatic int pick_model(input logic [N_REQ-1:0] mask, input int ptr);
      for (int k = 0; k < N_REQ; k++)
         if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
      return -1;
   endfunction

   assign bus.cvt_a_ack = bus.cvt_a_stb & cvt_ready;

   // Converter model: accepts an operand, answers after 0..3 cycles unless hung.
   initial begin
      bus.cvt_z_stb = 1'b0;
      bus.cvt_z     = 32'd0;
      pending  = 1'b0;
      nxt_a_hs = 1'b0;
      nxt_z_hs = 1'b0;
      nxt_a    = 32'd0;
      pend_delay = 0;
      pend_op  = 32'd0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pending       = 1'b0;
            bus.cvt_z_stb = 1'b0;
            nxt_a_hs      = 1'b0;
            nxt_z_hs      = 1'b0;
         end else begin
            if (nxt_z_hs) bus.cvt_z_stb = 1'b0;
            if (nxt_a_hs) begin
               pending    = 1'b1;
               pend_op    = nxt_a;
               pend_delay = $urandom_range(0, 3);
            end
            if (cvt_hang) pending = 1'b0;
            if (pending) begin
               if (pend_delay == 0) begin
                  bus.cvt_z_stb = 1'b1;
                  bus.cvt_z     = ref_i2f(pend_op);
                  pending       = 1'b0;
               end else begin
                  pend_delay--;
               end
            end
            nxt_a_hs = bus.cvt_a_stb & bus.cvt_a_ack;
            nxt_a    = bus.cvt_a;
            nxt_z_hs = bus.cvt_z_stb & bus.cvt_z_ack;
         end
      end
   end

   task automatic wait_ack(input int idx, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus.req_ack[idx] !== 1'b1 && lat < 200);
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus.resp_stb === '0 && lat < 400);
   endtask

   task automatic finish_resp(input int idx);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.resp_ack[idx] = 1'b1;
      @(negedge clk);
      bus.resp_ack[idx] = 1'b0;
      model_ptr = (idx + 1) % N_REQ;
   endtask

   task automatic run_one(input int idx, input logic [31:0] op, output logic [31:0] got,
                          output logic [N_REQ-1:0] got_stb, output int ack_lat);
      int rl;
      bus.req_data[32*idx +: 32] = op;
      bus.req_stb[idx] = 1'b1;
      wait_ack(idx, ack_lat);
      bus.req_stb[idx] = 1'b0;
      bus.req_data[32*idx +: 32] = $urandom;
      wait_resp(rl);
      got     = bus.resp_data;
      got_stb = bus.resp_stb;
      finish_resp(idx);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, timeout_err, bus.cvt_a_stb, bus.cvt_z_ack} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0000", {busy, timeout_err, bus.cvt_a_stb, bus.cvt_z_ack});
      end
      checks++;
      if (bus.req_ack !== '0 || bus.resp_stb !== '0 || grant_id !== '0) begin
         errors++;
         $display("FAIL reset_strobes: got ack %b resp %b grant %0d expected all 0", bus.req_ack, bus.resp_stb, grant_id);
      end
      checks++;
      if (bus.resp_data !== 32'd0 || bus.cvt_a !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: got resp %h cvt_a %h expected 0", bus.resp_data, bus.cvt_a);
      end
      rst = 1'b1;
      model_ptr = 0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.req_ack !== '0) begin
         errors++;
         $display("FAIL reset_release_idle: got busy %b ack %b expected 0", busy, bus.req_ack);
      end
   endtask

   task automatic test_single();
      int n, drops;
      bus.req_data[31:0] = 32'd1;
      bus.req_stb[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ack !== 2'b01 || grant_id !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_ack: got ack %b grant %0d busy %b expected 01 0 1", bus.req_ack, grant_id, busy);
      end
      checks++;
      if (bus.cvt_a_stb !== 1'b1 || bus.cvt_a !== 32'd1) begin
         errors++;
         $display("FAIL single_issue: got stb %b a %h expected 1 00000001", bus.cvt_a_stb, bus.cvt_a);
      end
      bus.req_stb[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ack !== 2'b00) begin
         errors++;
         $display("FAIL single_ack_pulse: got %b expected 00", bus.req_ack);
      end
      n = 0;
      drops = 0;
      while (bus.resp_stb === '0 && n < 100) begin
         if (busy !== 1'b1) drops++;
         @(negedge clk);
         n++;
      end
      checks++;
      if (drops != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy: got %0d low cycles expected 0", drops);
      end
      checks++;
      if (bus.resp_stb !== 2'b01 || bus.resp_data !== 32'h3F80_0000) begin
         errors++;
         $display("FAIL single_resp: got stb %b data %h expected 01 3f800000", bus.resp_stb, bus.resp_data);
      end
      bus.resp_ack[0] = 1'b1;
      @(negedge clk);
      bus.resp_ack[0] = 1'b0;
      model_ptr = 1;
      checks++;
      if (bus.resp_stb !== 2'b00 || busy !== 1'b0 || bus.resp_data !== 32'h3F80_0000) begin
         errors++;
         $display("FAIL single_release: got stb %b busy %b data %h expected 00 0 3f800000", bus.resp_stb, busy, bus.resp_data);
      end
   endtask

   task automatic test_values();
      logic [31:0] ops [0:7];
      logic [31:0] exps [0:7];
      logic [31:0] op, got;
      logic [N_REQ-1:0] gs;
      int idx, lat;
      ops  = '{32'hFFFF_FFFF, 32'h0, 32'd1, 32'd10, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0100_0001};
      exps = '{32'hBF80_0000, 32'h0, 32'h3F80_0000, 32'h4120_0000, 32'hC000_0000, 32'hCF00_0000, 32'h4F00_0000, 32'h4B80_0000};
      for (int k = 0; k < 20; k++) begin
         op  = (k < 8) ? ops[k] : $urandom;
         idx = $urandom_range(0, N_REQ - 1);
         run_one(idx, op, got, gs, lat);
         checks++;
         if (lat != 1) begin
            errors++;
            $display("FAIL values_ack_latency[%0d]: got %0d expected 1", k, lat);
         end
         checks++;
         if (gs !== oh(idx) || got !== ((k < 8) ? exps[k] : ref_i2f(op))) begin
            errors++;
            $display("FAIL values_result[%0d] op %h: got stb %b data %h expected %b %h", k, op, gs, got, oh(idx), (k < 8) ? exps[k] : ref_i2f(op));
         end
      end
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL values_timeout_err: got %b expected 0", timeout_err);
      end
   endtask

   task automatic test_contention();
      logic [31:0] op [0:N_REQ-1];
      int grants, resps, cyc, owner, exp_g;
      op[0] = 32'd10;
      op[1] = 32'hFFFF_FFFE;
      bus.req_data[31:0]  = op[0];
      bus.req_data[63:32] = op[1];
      bus.req_stb = '1;
      grants = 0;
      resps  = 0;
      cyc    = 0;
      owner  = 0;
      while (resps < 6 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         bus.resp_ack = '0;
         if (bus.req_ack !== '0) begin
            exp_g = pick_model('1, model_ptr);
            checks++;
            if (bus.req_ack !== oh(exp_g) || grant_id !== ID_W'(exp_g)) begin
               errors++;
               $display("FAIL contention_grant[%0d]: got ack %b id %0d expected %b %0d", grants, bus.req_ack, grant_id, oh(exp_g), exp_g);
            end
            owner = exp_g;
            grants++;
            if (grants == 6) bus.req_stb = '0;
         end
         if (bus.resp_stb !== '0) begin
            checks++;
            if (bus.resp_stb !== oh(owner) || bus.resp_data !== ref_i2f(op[owner])) begin
               errors++;
               $display("FAIL contention_resp[%0d]: got stb %b data %h expected %b %h", resps, bus.resp_stb, bus.resp_data, oh(owner), ref_i2f(op[owner]));
            end
            bus.resp_ack = oh(owner);
            model_ptr = (owner + 1) % N_REQ;
            resps++;
         end
      end
      @(negedge clk);
      bus.resp_ack = '0;
      bus.req_stb  = '0;
      checks++;
      if (resps != 6) begin
         errors++;
         $display("FAIL contention_count: got %0d responses expected 6", resps);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] op0, op1;
      int lat, bad;
      op0 = $urandom;
      op1 = $urandom;
      bus.req_data[63:32] = op1;
      bus.req_stb[1] = 1'b1;
      wait_ack(1, lat);
      bus.req_stb[1] = 1'b0;
      wait_resp(lat);
      bus.req_data[31:0] = op0;
      bus.req_stb[0] = 1'b1;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         bus.resp_ack = {1'b0, 1'($urandom)};
         @(negedge clk);
         if (bus.resp_stb !== 2'b10 || bus.resp_data !== ref_i2f(op1) || bus.req_ack !== 2'b00 || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL backpressure_hold: got %0d unstable cycles expected 0 (stb %b data %h)", bad, bus.resp_stb, bus.resp_data);
      end
      bus.resp_ack = 2'b10;
      @(negedge clk);
      bus.resp_ack = '0;
      model_ptr = 0;
      checks++;
      if (bus.resp_stb !== 2'b00) begin
         errors++;
         $display("FAIL backpressure_release: got %b expected 00", bus.resp_stb);
      end
      wait_ack(0, lat);
      bus.req_stb[0] = 1'b0;
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL backpressure_next_ack: got %0d cycles expected 1", lat);
      end
      wait_resp(lat);
      checks++;
      if (bus.resp_stb !== 2'b01 || bus.resp_data !== ref_i2f(op0)) begin
         errors++;
         $display("FAIL backpressure_second: got %b %h expected 01 %h", bus.resp_stb, bus.resp_data, ref_i2f(op0));
      end
      finish_resp(0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] ops [0:2];
      int idx, lat;
      idx = $urandom_range(0, N_REQ - 1);
      for (int t = 0; t < 3; t++) ops[t] = $urandom;
      bus.req_data[32*idx +: 32] = ops[0];
      bus.req_stb[idx] = 1'b1;
      for (int t = 0; t < 3; t++) begin
         wait_ack(idx, lat);
         checks++;
         if (lat != 1) begin
            errors++;
            $display("FAIL b2b_ack_latency[%0d]: got %0d expected 1", t, lat);
         end
         if (t < 2) bus.req_data[32*idx +: 32] = ops[t + 1];
         else bus.req_stb[idx] = 1'b0;
         wait_resp(lat);
         checks++;
         if (bus.resp_stb !== oh(idx) || bus.resp_data !== ref_i2f(ops[t])) begin
            errors++;
            $display("FAIL b2b_resp[%0d]: got %b %h expected %b %h", t, bus.resp_stb, bus.resp_data, oh(idx), ref_i2f(ops[t]));
         end
         bus.resp_ack[idx] = 1'b1;
         @(negedge clk);
         bus.resp_ack[idx] = 1'b0;
         model_ptr = (idx + 1) % N_REQ;
         checks++;
         if (busy !== 1'b0 || bus.req_ack !== '0) begin
            errors++;
            $display("FAIL b2b_idle_gap[%0d]: got busy %b ack %b expected 0 00", t, busy, bus.req_ack);
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] got;
      logic [N_REQ-1:0] gs;
      int idx, lat, n;
      logic [31:0] op;
      for (int mode = 0; mode < 2; mode++) begin
         if (mode == 0) cvt_ready = 1'b0;
         else cvt_hang = 1'b1;
         idx = $urandom_range(0, N_REQ - 1);
         bus.req_data[32*idx +: 32] = $urandom;
         bus.req_stb[idx] = 1'b1;
         wait_ack(idx, lat);
         bus.req_stb[idx] = 1'b0;
         wait_resp(n);
         checks++;
         if (n != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency[%0d]: got %0d cycles expected %0d", mode, n, TIMEOUT);
         end
         checks++;
         if (bus.resp_data !== 32'h7FC0_0000 || bus.resp_stb !== oh(idx) || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result[%0d]: got %h %b err %b expected 7fc00000 %b 1", mode, bus.resp_data, bus.resp_stb, timeout_err, oh(idx));
         end
         finish_resp(idx);
         cvt_ready = 1'b1;
         cvt_hang  = 1'b0;
      end
      op  = $urandom;
      idx = $urandom_range(0, N_REQ - 1);
      run_one(idx, op, got, gs, lat);
      checks++;
      if (got !== ref_i2f(op) || gs !== oh(idx)) begin
         errors++;
         $display("FAIL timeout_recovery: got %h %b expected %h %b", got, gs, ref_i2f(op), oh(idx));
      end
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] op0, op1;
      int lat, exp_g;
      cvt_hang = 1'b1;
      bus.req_data[31:0] = $urandom;
      bus.req_stb[0] = 1'b1;
      wait_ack(0, lat);
      bus.req_stb[0] = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.cvt_z_ack !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midreset_wait: got z_ack %b busy %b expected 1 1", bus.cvt_z_ack, busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy, timeout_err, bus.cvt_a_stb, bus.cvt_z_ack} !== 4'b0000 || bus.req_ack !== '0 || bus.resp_stb !== '0) begin
         errors++;
         $display("FAIL midreset_ctrl: got %b ack %b resp %b expected 0000 00 00", {busy, timeout_err, bus.cvt_a_stb, bus.cvt_z_ack}, bus.req_ack, bus.resp_stb);
      end
      checks++;
      if (bus.resp_data !== 32'd0 || bus.cvt_a !== 32'd0 || grant_id !== '0) begin
         errors++;
         $display("FAIL midreset_data: got %h %h %0d expected 0 0 0", bus.resp_data, bus.cvt_a, grant_id);
      end
      @(negedge clk);
      rst = 1'b1;
      cvt_hang = 1'b0;
      model_ptr = 0;
      op0 = $urandom;
      op1 = $urandom;
      bus.req_data[31:0]  = op0;
      bus.req_data[63:32] = op1;
      bus.req_stb = '1;
      exp_g = pick_model('1, model_ptr);
      wait_ack(exp_g, lat);
      checks++;
      if (bus.req_ack !== 2'b01 || grant_id !== 1'b0) begin
         errors++;
         $display("FAIL midreset_first_grant: got %b %0d expected 01 0", bus.req_ack, grant_id);
      end
      bus.req_stb[0] = 1'b0;
      wait_resp(lat);
      checks++;
      if (bus.resp_stb !== 2'b01 || bus.resp_data !== ref_i2f(op0)) begin
         errors++;
         $display("FAIL midreset_resp0: got %b %h expected 01 %h", bus.resp_stb, bus.resp_data, ref_i2f(op0));
      end
      finish_resp(0);
      wait_ack(1, lat);
      bus.req_stb[1] = 1'b0;
      wait_resp(lat);
      checks++;
      if (bus.resp_stb !== 2'b10 || bus.resp_data !== ref_i2f(op1)) begin
         errors++;
         $display("FAIL midreset_resp1: got %b %h expected 10 %h", bus.resp_stb, bus.resp_data, ref_i2f(op1));
      end
      finish_resp(1);
   endtask

   initial begin
      bus.req_stb  = '0;
      bus.req_data = '0;
      bus.resp_ack = '0;
      test_reset();
      test_single();
      test_values();
      test_contention();
      test_backpressure();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got still running expected finished");
      $fatal(1, "time limit");
   end
endmodule
